vec_reg_sequencer: RTL and testbench
====================================

Name: vec_reg_sequencer

Overview:
- Datapath-side register-index walker for the extended vector instructions: dot product, vector/scalar multiply and vector add.
- Microcode loads the base register numbers and opcode, then issues one step strobe per element.
- The block returns RM_CNTR, RN_CNTR and RD_CNTR to the register-file ports, and returns RM_CNTR_DONE and a first-element flag to the state machine.
- It is the producer end of the RM_CNTR / RM_CNTR_DONE interface that the microsequencer consumes.

Parameters:
- VLEN, 5, number of elements per vector operation (2..16).
- REG_W, 4, register-number width; index arithmetic wraps modulo 2^REG_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low: asserts immediately, releases synchronously to clk.
- load  input  1  start strobe from microcode; samples the base numbers and OP.
- step  input  1  advance-one-element strobe from microcode.
- OP  input  2  IR[24:23]: 01 = dot product, 10 = vector×scalar, 11 = vector add, 00 = illegal.
- base_m  input  REG_W  first Rm register number.
- base_n  input  REG_W  first Rn register number (the scalar register for OP=10).
- base_d  input  REG_W  first Rd register number (the accumulator for OP=01).
- RM_CNTR  output  REG_W  current Rm index.
- RN_CNTR  output  REG_W  current Rn index.
- RD_CNTR  output  REG_W  current Rd index.
- elem_cnt  output  4  element number, 0..VLEN-1.
- RM_CNTR_DONE  output  1  current element is the last one.
- first  output  1  current element is element 0 (drives DOT_PROD_RST qualification).
- busy  output  1  sequence in progress.
- op_err  output  1  one-cycle pulse when load is issued with OP=00.

Behaviour:
- Reset (rst=0, asynchronous) sets: state IDLE, all indices 0, elem_cnt 0, busy 0, op_err 0.
- States: IDLE and RUN. All outputs are registered, except RM_CNTR_DONE = busy & (elem_cnt==VLEN-1) and first = busy & (elem_cnt==0).
- IDLE, load, OP≠00: next cycle enters RUN with RM/RN/RD_CNTR = base_m/base_n/base_d, elem_cnt 0, busy 1. Latency load→valid indices is 1 cycle. OP is latched internally.
- IDLE or RUN, load, OP=00: op_err pulses 1 the next cycle. State, indices and latched OP are unchanged.
- RUN, step, elem_cnt<VLEN-1: elem_cnt+1 and indices update per the latched OP:
  - OP=01: RM+1, RN+1, RD held (single accumulator).
  - OP=10: RM+1, RD+1, RN held (scalar).
  - OP=11: RM+1, RN+1, RD+1.
- RUN, step, elem_cnt==VLEN-1: return to IDLE, busy 0. Indices and elem_cnt hold their last values so the retire cycle can still read them. RM_CNTR_DONE and first drop because busy=0.
- Index wrap: all index adds are modulo 2^REG_W (base 14, VLEN 5 → 14,15,0,1,2). Done is derived from elem_cnt only, never from the index value.
- load and step in the same cycle: load wins (restart from the new bases). A legal load while in RUN aborts the current sequence and restarts.
- step in IDLE: ignored, no state change.
- rst asserted mid-sequence: immediate return to the reset values. No completion is signalled.
- VLEN=1: RM_CNTR_DONE and first are both 1 on the single element; one step returns to IDLE.

Test Plan:
1. Reset, then load OP=01, base_m=0, base_n=5, base_d=10; step ×4 → RM 0..4, RN 5..9, RD stays 10. RM_CNTR_DONE=1 only at RM=4. first=1 only at element 0. A 5th step gives busy=0.
2. Load OP=10, base_m=5, base_n=3, base_d=11 → RM 5..9, RD 11..15, RN held 3. DONE asserts when RM=9.
3. Load OP=11, base_m=14, base_n=0, base_d=7 → RM 14,15,0,1,2 (wrap), RN 0..4, RD 7..11. DONE at elem_cnt=4, i.e. RM=2.
4. Load OP=00 in IDLE → op_err one-cycle pulse, busy stays 0. Step in IDLE → no change.
5. During OP=11 at elem 2, assert load and step together with base_m=8 → next cycle RM=8, elem_cnt=0, first=1.
6. Pull rst low asynchronously mid-sequence at elem 3 → busy, RM_CNTR_DONE and indices go to 0 before the next clk edge. After release, a step is ignored until the next load.

Source files
------------

// File: rtl/vec_reg_sequencer.sv
// Register-index walker for vector dot, vector x scalar and vector add.
// Steps Rm/Rn/Rd per element and reports first/last element to microcode.
module vec_reg_sequencer #(
    parameter int VLEN  = 5,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       OP,
    input  logic [REG_W-1:0] base_m,
    input  logic [REG_W-1:0] base_n,
    input  logic [REG_W-1:0] base_d,
    output logic [REG_W-1:0] RM_CNTR,
    output logic [REG_W-1:0] RN_CNTR,
    output logic [REG_W-1:0] RD_CNTR,
    output logic [3:0]       elem_cnt,
    output logic             RM_CNTR_DONE,
    output logic             first,
    output logic             busy,
    output logic             op_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST = 4'(VLEN - 1);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [1:0]       r_op;
    logic [REG_W-1:0] r_rm;
    logic [REG_W-1:0] r_rn;
    logic [REG_W-1:0] r_rd;
    logic [3:0]       r_cnt;
    logic             r_op_err;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_last;
    logic             w_adv;

    assign w_rst_n    = r_rst_sync[1];
    assign w_load_ok  = load & (OP != 2'b00);
    assign w_load_bad = load & (OP == 2'b00);
    assign w_last     = (r_cnt == LAST);
    // any load blocks a same-cycle step, legal or not
    assign w_adv      = (r_state == S_RUN) & step & ~load;

    // reset asserts at once, deasserts two edges after rst rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rst_sync <= 2'b00;
        else      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // state register
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next-state: legal load (re)starts, final step retires
    always_comb begin
        w_next = r_state;
        if (w_load_ok)
            w_next = S_RUN;
        else if (w_adv && w_last)
            w_next = S_IDLE;
    end

    // index, element and opcode registers
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_op     <= 2'b00;
            r_rm     <= '0;
            r_rn     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_op_err <= 1'b0;
        end else begin
            r_op_err <= w_load_bad;
            if (w_load_ok) begin
                r_op  <= OP;
                r_rm  <= base_m;
                r_rn  <= base_n;
                r_rd  <= base_d;
                r_cnt <= '0;
            end else if (w_adv && !w_last) begin
                r_cnt <= r_cnt + 4'd1;
                r_rm  <= r_rm + 1'b1;
                unique case (r_op)
                    2'b01:   r_rn <= r_rn + 1'b1;
                    2'b10:   r_rd <= r_rd + 1'b1;
                    2'b11: begin
                        r_rn <= r_rn + 1'b1;
                        r_rd <= r_rd + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // outputs; done/first qualified by busy so they drop on retire
    always_comb begin
        busy         = (r_state == S_RUN);
        RM_CNTR_DONE = busy & w_last;
        first        = busy & (r_cnt == 4'd0);
        RM_CNTR      = r_rm;
        RN_CNTR      = r_rn;
        RD_CNTR      = r_rd;
        elem_cnt     = r_cnt;
        op_err       = r_op_err;
    end

endmodule

// File: tb/tb_vec_reg_sequencer.sv
// Directed bench for vec_reg_sequencer with hand-computed expectations.
// Packed compare: {busy,first,done,op_err,elem,RM,RN,RD}.
module tb_vec_reg_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       step;
    logic [1:0] OP;
    logic [3:0] base_m;
    logic [3:0] base_n;
    logic [3:0] base_d;
    logic [3:0] RM_CNTR;
    logic [3:0] RN_CNTR;
    logic [3:0] RD_CNTR;
    logic [3:0] elem_cnt;
    logic       RM_CNTR_DONE;
    logic       first;
    logic       busy;
    logic       op_err;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [23:0] got;
    logic [23:0] exp;

    vec_reg_sequencer #(.VLEN(5), .REG_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .OP           (OP),
        .base_m       (base_m),
        .base_n       (base_n),
        .base_d       (base_d),
        .RM_CNTR      (RM_CNTR),
        .RN_CNTR      (RN_CNTR),
        .RD_CNTR      (RD_CNTR),
        .elem_cnt     (elem_cnt),
        .RM_CNTR_DONE (RM_CNTR_DONE),
        .first        (first),
        .busy         (busy),
        .op_err       (op_err)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [1:0] op, input logic [3:0] m,
                           input logic [3:0] n, input logic [3:0] d);
        OP = op; base_m = m; base_n = n; base_d = d;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic do_step;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
    endtask

    task automatic sample;
        got = {busy, first, RM_CNTR_DONE, op_err, elem_cnt,
               RM_CNTR, RN_CNTR, RD_CNTR};
    endtask

    task automatic test_reset;
        rst = 1'b0; load = 1'b0; step = 1'b0;
        OP = 2'b00; base_m = '0; base_n = '0; base_d = '0;
        repeat (3) @(posedge clk);
        #1;
        sample();
        exp = 24'h000000;
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL reset: got %h want %h", got, exp);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_dot_product;
        do_load(2'b01, 4'd0, 4'd5, 4'd10);
        for (int e = 0; e < 5; e++) begin
            sample();
            exp = {1'b1, 1'(e == 0), 1'(e == 4), 1'b0, 4'(e),
                   4'(e), 4'(5 + e), 4'd10};
            n_vec++;
            if (got !== exp) begin
                n_miss++;
                $display("FAIL dot e%0d: got %h want %h", e, got, exp);
            end
            do_step();
        end
        sample();
        exp = {4'b0000, 4'd4, 4'd4, 4'd9, 4'd10};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL dot retire: got %h want %h", got, exp);
        end
    endtask

    task automatic test_vec_scalar;
        do_load(2'b10, 4'd5, 4'd3, 4'd11);
        for (int e = 0; e < 5; e++) begin
            sample();
            exp = {1'b1, 1'(e == 0), 1'(e == 4), 1'b0, 4'(e),
                   4'(5 + e), 4'd3, 4'(11 + e)};
            n_vec++;
            if (got !== exp) begin
                n_miss++;
                $display("FAIL vxs e%0d: got %h want %h", e, got, exp);
            end
            do_step();
        end
        sample();
        exp = {4'b0000, 4'd4, 4'd9, 4'd3, 4'd15};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL vxs retire: got %h want %h", got, exp);
        end
    endtask

    task automatic test_vec_add_wrap;
        logic [3:0] rm_tab [5];
        rm_tab = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
        do_load(2'b11, 4'd14, 4'd0, 4'd7);
        for (int e = 0; e < 5; e++) begin
            sample();
            exp = {1'b1, 1'(e == 0), 1'(e == 4), 1'b0, 4'(e),
                   rm_tab[e], 4'(e), 4'(7 + e)};
            n_vec++;
            if (got !== exp) begin
                n_miss++;
                $display("FAIL vadd e%0d: got %h want %h", e, got, exp);
            end
            do_step();
        end
        sample();
        exp = {4'b0000, 4'd4, 4'd2, 4'd4, 4'd11};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL vadd retire: got %h want %h", got, exp);
        end
    endtask

    task automatic test_illegal_idle;
        do_load(2'b00, 4'd1, 4'd2, 4'd3);
        sample();
        exp = {4'b0001, 4'd4, 4'd2, 4'd4, 4'd11};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL operr pulse: got %h want %h", got, exp);
        end
        @(posedge clk); #1;
        sample();
        exp = {4'b0000, 4'd4, 4'd2, 4'd4, 4'd11};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL operr drop: got %h want %h", got, exp);
        end
        do_step();
        sample();
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL idle step: got %h want %h", got, exp);
        end
    endtask

    task automatic test_back_to_back;
        do_load(2'b11, 4'd14, 4'd0, 4'd7);
        do_step();
        do_step();
        sample();
        exp = {4'b1000, 4'd2, 4'd0, 4'd2, 4'd9};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL abort pre: got %h want %h", got, exp);
        end
        OP = 2'b11; base_m = 4'd8; base_n = 4'd1; base_d = 4'd2;
        load = 1'b1; step = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; step = 1'b0;
        sample();
        exp = {4'b1100, 4'd0, 4'd8, 4'd1, 4'd2};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL restart: got %h want %h", got, exp);
        end
        OP = 2'b00; base_m = 4'd3; load = 1'b1; step = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; step = 1'b0;
        sample();
        exp = {4'b1101, 4'd0, 4'd8, 4'd1, 4'd2};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL run operr: got %h want %h", got, exp);
        end
        do_step();
        sample();
        exp = {4'b1000, 4'd1, 4'd9, 4'd2, 4'd3};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL post restart: got %h want %h", got, exp);
        end
    endtask

    task automatic test_async_reset;
        do_load(2'b01, 4'd0, 4'd5, 4'd10);
        do_step();
        do_step();
        do_step();
        sample();
        exp = {4'b1000, 4'd3, 4'd3, 4'd8, 4'd10};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL pre reset: got %h want %h", got, exp);
        end
        #2 rst = 1'b0;
        #1;
        sample();
        exp = 24'h000000;
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL async reset: got %h want %h", got, exp);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_step();
        sample();
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL step after reset: got %h want %h", got, exp);
        end
        do_load(2'b10, 4'd5, 4'd3, 4'd11);
        sample();
        exp = {4'b1100, 4'd0, 4'd5, 4'd3, 4'd11};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL reload: got %h want %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_dot_product();
        test_vec_scalar();
        test_vec_add_wrap();
        test_illegal_idle();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
